// File: rtl/uart_tx_control.sv
// UART transmit control: one-entry holding register feeding an
// LSB-first serialiser that emits start, data, optional parity and stop bits.
//
// Ports:
//   CLK      system clock, all state updates on the rising edge
//   RST_N    asynchronous active-low reset
//   TXC      bit-period strobe, one CLK cycle wide per bit time
//   TXDATA   word to transmit, sampled when a write is accepted
//   TXWR     write strobe, accepted only while TXRDY=1
//   TXRDY    holding register empty
//   TXEMPTY  holding register empty and serialiser idle (registered)
//   TXD      serial line, registered, idles high
module uart_tx_control #(
    parameter int SIZE       = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            TXC,
    input  logic [SIZE-1:0] TXDATA,
    input  logic            TXWR,
    output logic            TXRDY,
    output logic            TXEMPTY,
    output logic            TXD
);

    localparam int BW = $clog2(SIZE + 1);
    localparam logic [BW-1:0] LAST = BW'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic [SIZE-1:0] hold;
    logic [SIZE-1:0] shift;
    logic            hold_full;
    logic            par;
    logic            stop_cnt;
    logic [BW-1:0]   bit_cnt;
    logic            wr_ok;

    // A write arriving while the holding register is full is dropped.
    assign wr_ok = TXWR & ~hold_full;
    assign TXRDY = ~hold_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            hold      <= '0;
            shift     <= '0;
            hold_full <= 1'b0;
            par       <= 1'b0;
            stop_cnt  <= 1'b0;
            bit_cnt   <= '0;
            TXD       <= 1'b1;
            TXEMPTY   <= 1'b1;
        end else begin
            if (wr_ok) begin
                hold      <= TXDATA;
                hold_full <= 1'b1;
            end
            TXEMPTY <= (state == IDLE) & ~hold_full;

            // A load from holding only happens when it is full, so it can
            // never collide with an accepted write in the same cycle.
            if (TXC) begin
                unique case (state)
                    IDLE: begin
                        if (hold_full) begin
                            shift     <= hold;
                            hold_full <= 1'b0;
                            par       <= 1'b0;
                            TXD       <= 1'b0;
                            state     <= START;
                        end else begin
                            TXD <= 1'b1;
                        end
                    end
                    START: begin
                        bit_cnt <= '0;
                        TXD     <= shift[0];
                        state   <= DATA;
                    end
                    DATA: begin
                        shift   <= shift >> 1;
                        par     <= par ^ shift[0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST) begin
                            if (PARITY_EN != 0) begin
                                TXD   <= par ^ shift[0] ^ (PARITY_ODD != 0);
                                state <= PARITY;
                            end else begin
                                TXD      <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            TXD <= shift[1];
                        end
                    end
                    PARITY: begin
                        TXD      <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (STOP_BITS == 2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else if (hold_full) begin
                            // Queued word starts with no idle bit between.
                            shift     <= hold;
                            hold_full <= 1'b0;
                            par       <= 1'b0;
                            TXD       <= 1'b0;
                            state     <= START;
                        end else begin
                            TXD   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        TXD   <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_control.sv
// Bench for uart_tx_control: four parameterisations, a line-level frame
// decoder checked against a scoreboard, plus directed timing sequences.
module tb_uart_tx_control;

    logic       CLK;
    logic       RST_N;
    logic       TXC;
    logic [7:0] txdata  [4];
    logic       txwr    [4];
    logic       txrdy   [4];
    logic       txempty [4];
    logic       txd     [4];

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int         s;
        logic [7:0] d;
        logic       p;
        int         len;
    } vec_t;
    vec_t vt[7];

    // 0: plain 8N1, 1: even parity, 2: odd parity, 3: 8N2
    uart_tx_control #(.SIZE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TXDATA(txdata[0]), .TXWR(txwr[0]),
        .TXRDY(txrdy[0]), .TXEMPTY(txempty[0]), .TXD(txd[0]));
    uart_tx_control #(.SIZE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TXDATA(txdata[1]), .TXWR(txwr[1]),
        .TXRDY(txrdy[1]), .TXEMPTY(txempty[1]), .TXD(txd[1]));
    uart_tx_control #(.SIZE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TXDATA(txdata[2]), .TXWR(txwr[2]),
        .TXRDY(txrdy[2]), .TXEMPTY(txempty[2]), .TXD(txd[2]));
    uart_tx_control #(.SIZE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .CLK(CLK), .RST_N(RST_N), .TXC(TXC), .TXDATA(txdata[3]), .TXWR(txwr[3]),
        .TXRDY(txrdy[3]), .TXEMPTY(txempty[3]), .TXD(txd[3]));

    function automatic bit has_par(int s);
        return (s == 1) || (s == 2);
    endfunction

    function automatic int n_stop(int s);
        return (s == 3) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        exp_q.push_back(e);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Baud strobe: high for one CLK in every 16.
    initial begin
        TXC = 1'b0;
        forever begin
            repeat (15) @(posedge CLK);
            #1 TXC = 1'b1;
            @(posedge CLK);
            #1 TXC = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Wait n falling edges; report an abort if reset shows up.
    task automatic mwait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (!RST_N) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // Line decoder: samples each bit at its centre on the selected DUT.
    initial begin
        logic [7:0] d;
        logic       p;
        bit         ab;
        int         s;
        exp_t       e;
        d = '0;
        p = 1'b0;
        forever begin
            @(negedge CLK);
            s = sel;
            if (!RST_N || txd[s] !== 1'b0) continue;
            mwait(8, ab);
            if (ab) continue;
            chk("mon_start_bit", txd[s], 0);
            for (int i = 0; i < 8 && !ab; i++) begin
                mwait(16, ab);
                if (!ab) d[i] = txd[s];
            end
            if (!ab && has_par(s)) begin
                mwait(16, ab);
                if (!ab) p = txd[s];
            end
            for (int k = 0; k < n_stop(s) && !ab; k++) begin
                mwait(16, ab);
                if (!ab) chk("mon_stop_bit", txd[s], 1);
            end
            if (!ab) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_frame", {24'h0, d}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_data", d, e.d);
                    if (has_par(s)) chk("mon_parity", p, e.p);
                end
            end
        end
    end

    task automatic do_write(input int s, input logic [7:0] d);
        @(posedge CLK);
        #1;
        txwr[s]   = 1'b1;
        txdata[s] = d;
        @(posedge CLK);
        #1;
        txwr[s] = 1'b0;
    endtask

    task automatic wait_start(input int s);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(posedge CLK);
            #1;
            if (txd[s] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("start_seen", ok, 1);
    endtask

    // Counts bit strobes after the start edge until TXEMPTY rises.
    task automatic count_frame(input int s, input int len);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 16 * 40; i++) begin
            @(posedge CLK);
            if (TXC) n++;
            #1;
            if (txempty[s] === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        chk("empty_reached", done, 1);
        chk("frame_strobes", n, len);
    endtask

    initial begin
        int  n;
        bit  ok;

        vt[0] = '{s: 0, d: 8'h55, p: 1'b0, len: 10};
        vt[1] = '{s: 1, d: 8'h07, p: 1'b1, len: 11};
        vt[2] = '{s: 2, d: 8'h07, p: 1'b0, len: 11};
        vt[3] = '{s: 1, d: 8'h00, p: 1'b0, len: 11};
        vt[4] = '{s: 2, d: 8'hFF, p: 1'b1, len: 11};
        vt[5] = '{s: 1, d: 8'h80, p: 1'b1, len: 11};
        vt[6] = '{s: 3, d: 8'h3C, p: 1'b0, len: 11};

        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            txwr[i]   = 1'b0;
            txdata[i] = 8'h00;
        end
        repeat (5) @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_txd", txd[i], 1);
            chk("reset_txrdy", txrdy[i], 1);
            chk("reset_txempty", txempty[i], 1);
        end
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        foreach (vt[i]) begin
            sel = vt[i].s;
            push_exp(vt[i].d, vt[i].p);
            do_write(vt[i].s, vt[i].d);
            chk("rdy_low_after_wr", txrdy[vt[i].s], 0);
            wait_start(vt[i].s);
            chk("rdy_high_at_start", txrdy[vt[i].s], 1);
            count_frame(vt[i].s, vt[i].len);
            repeat (3) @(posedge CLK);
            #1;
        end

        // Write coinciding with a strobe in IDLE starts on the next strobe.
        sel = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            if (TXC) break;
        end
        repeat (15) @(posedge CLK);
        #1;
        txwr[0]   = 1'b1;
        txdata[0] = 8'hC3;
        push_exp(8'hC3, 1'b0);
        @(posedge CLK);
        #1;
        txwr[0] = 1'b0;
        chk("no_start_same_strobe", txd[0], 1);
        chk("held_after_same_strobe", txrdy[0], 0);
        n = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge CLK);
            if (TXC) n++;
            #1;
            if (txd[0] === 1'b0) break;
        end
        chk("start_on_next_strobe", n, 1);
        count_frame(0, 10);

        // Back-to-back: no idle gap between frames.
        push_exp(8'hA5, 1'b0);
        do_write(0, 8'hA5);
        wait_start(0);
        push_exp(8'h3C, 1'b0);
        do_write(0, 8'h3C);
        count_frame(0, 20);

        // Overrun: third write while full is dropped.
        push_exp(8'h11, 1'b0);
        do_write(0, 8'h11);
        wait_start(0);
        push_exp(8'h22, 1'b0);
        do_write(0, 8'h22);
        chk("overrun_rdy_low", txrdy[0], 0);
        do_write(0, 8'h33);
        count_frame(0, 20);
        repeat (3) @(posedge CLK);
        #1;

        // Two stop bits, with a queued word following.
        sel = 3;
        push_exp(8'hFF, 1'b0);
        do_write(3, 8'hFF);
        wait_start(3);
        push_exp(8'h01, 1'b0);
        do_write(3, 8'h01);
        count_frame(3, 22);
        repeat (3) @(posedge CLK);
        #1;

        // Reset during data bit 3 with a word queued in holding.
        sel = 0;
        push_exp(8'h52, 1'b0);
        do_write(0, 8'h52);
        wait_start(0);
        do_write(0, 8'h77);
        chk("queued_rdy_low", txrdy[0], 0);
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(posedge CLK);
            if (TXC) n++;
        end
        repeat (5) @(posedge CLK);
        #3;
        chk("bit3_before_reset", txd[0], 0);
        RST_N = 1'b0;
        #1;
        chk("abort_txd", txd[0], 1);
        chk("abort_txrdy", txrdy[0], 1);
        chk("abort_txempty", txempty[0], 1);
        repeat (3) @(posedge CLK);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (txd[0] !== 1'b1 || txempty[0] !== 1'b1) ok = 1'b0;
        end
        chk("no_residue_after_reset", ok, 1);
        push_exp(8'h81, 1'b0);
        do_write(0, 8'h81);
        wait_start(0);
        count_frame(0, 10);

        repeat (20) @(posedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
